regfile_access_ctrl: RTL and testbench
======================================

Name: regfile_access_ctrl

Overview:
Command-driven initiator that sits in front of the 32x32 register file and owns the file's write and dual-read ports. It accepts write and read commands over a valid/ready interface and sequences the register-file strobes. On writes it waits for the file's registered write acknowledge, with a timeout. On reads it captures both registered read outputs and returns them over a valid/ready response interface.

Parameters:
DATA_WIDTH, 32, register data width
ADDR_WIDTH, 5, register address width
ACK_TIMEOUT, 4, WAIT_ACK cycles allowed before a write is failed (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when high with cmd_valid
cmd_write  input  1  1=write, 0=dual read
cmd_addr_a  input  ADDR_WIDTH  write address / read port-1 address
cmd_addr_b  input  ADDR_WIDTH  read port-2 address (ignored on write)
cmd_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  response present
rsp_ready  input  1  response consumed when high with rsp_valid
rsp_data_a  output  DATA_WIDTH  read port-1 data
rsp_data_b  output  DATA_WIDTH  read port-2 data
rsp_err  output  1  1=write ack timeout (or verify mismatch)
rf_wr_en  output  1  register-file write enable
rf_wr_addr  output  ADDR_WIDTH  register-file write address
rf_wr_data  output  DATA_WIDTH  register-file write data
rf_rd_addr1  output  ADDR_WIDTH  register-file read address 1
rf_rd_addr2  output  ADDR_WIDTH  register-file read address 2
rf_rd_data1  input  DATA_WIDTH  register-file read data 1 (registered in file)
rf_rd_data2  input  DATA_WIDTH  register-file read data 2 (registered in file)
rf_wr_ack  input  1  register-file write acknowledge (registered in file)
busy  output  1  high in any state other than IDLE

Behaviour:
- Clocking: single clock clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0, except cmd_ready=1 (state IDLE). State=IDLE, timeout counter=0.
- Reset mid-operation: the in-flight command is dropped; rf_wr_en drops immediately; no response is produced.
- Registered outputs: all rf_* outputs and rsp_* data/valid/err are registered.
- Combinational outputs: cmd_ready = (state==IDLE); busy = !cmd_ready.
- States: IDLE, WR, WAIT_ACK, RD, RD_CAP, RESP.
- IDLE: on cmd_valid at edge E0, latch the command.
  - Write: go to WR, set rf_wr_en=1, rf_wr_addr=cmd_addr_a, rf_wr_data=cmd_wdata.
  - Read: go to RD, set rf_rd_addr1=cmd_addr_a, rf_rd_addr2=cmd_addr_b.
- WR: lasts exactly one cycle. At the next edge, rf_wr_en->0, counter cleared, go to WAIT_ACK.
- WAIT_ACK:
  - rf_wr_ack=1 at an edge -> RESP, rsp_err=0.
  - Otherwise the counter increments. When counter reaches ACK_TIMEOUT with no ack -> RESP, rsp_err=1.
  - Ack and final count on the same edge: ack wins, err=0.
  - Write responses return rsp_data_a/b = 0.
- RD: one cycle; the file samples the addresses at the next edge; go to RD_CAP.
- RD_CAP: at the next edge, rsp_data_a<=rf_rd_data1, rsp_data_b<=rf_rd_data2, rsp_err=0 -> RESP.
- RESP: rsp_valid=1. Data and err are held stable until rsp_ready is sampled high. Then rsp_valid->0 and state->IDLE; cmd_ready returns the following cycle (no same-cycle turnaround).
- Latency from the acceptance edge to rsp_valid:
  - read: 3 edges;
  - write with prompt ack: 3 edges;
  - write timeout: 2+ACK_TIMEOUT edges.
- rf_rd_addr1/2 hold their last value outside RD.
- rf_wr_addr/data hold their values after WR; only rf_wr_en is pulsed.
- rf_wr_ack seen outside WAIT_ACK is ignored; it never creates a response.
- Address/data widths pass through unmodified; there are no range checks (all 2^ADDR_WIDTH addresses are legal).

Optional Feature:
WRITE_VERIFY_EN
- Defined: after a successful ack, WAIT_ACK goes to RD with rf_rd_addr1 = latched write address; then RD_CAP.
  - rsp_data_a = read-back value.
  - rsp_err = (read-back != latched wdata).
  - Write latency with prompt ack becomes 5 edges.
  - A timeout still skips the read-back (err=1).
- Undefined: write path is WR->WAIT_ACK->RESP as above, with no read-back logic.

Test Plan:
- Reset: assert rst_n=0 mid-WR -> rf_wr_en=0 immediately; after release, cmd_ready=1, rsp_valid=0, no response.
- Write addr 5 data 0xDEADBEEF, model acks one edge after rf_wr_en -> single-cycle rf_wr_en with addr 5 / data 0xDEADBEEF; rsp_valid 3 edges after acceptance, rsp_err=0.
- Dual read addr 5 and addr 9 (preloaded 0xDEADBEEF, 0x00000009) -> rsp_data_a=0xDEADBEEF, rsp_data_b=0x00000009, 3 edges after acceptance.
- Write with ack never asserted, ACK_TIMEOUT=4 -> rsp_err=1 exactly 6 edges after acceptance; next command accepted normally.
- Backpressure: hold rsp_ready=0 for 5 cycles during a read response -> rsp_valid, data and err stable; cmd_ready=0 throughout; the ack-free stray rf_wr_ack pulse is ignored.
- WRITE_VERIFY_EN: model corrupts bit 0 on write of 0x12345678 -> rsp_data_a=0x12345679, rsp_err=1; an uncorrupted write -> rsp_err=0.

Source files
------------

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: command-driven initiator owning the register file ports.
// Optional read-back verify of writes: define WRITE_VERIFY_EN.
module regfile_access_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_a,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_b,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data_a,
  output logic [DATA_WIDTH-1:0] rsp_data_b,
  output logic                  rsp_err,
  output logic                  rf_wr_en,
  output logic [ADDR_WIDTH-1:0] rf_wr_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr1,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr2,
  input  logic [DATA_WIDTH-1:0] rf_rd_data1,
  input  logic [DATA_WIDTH-1:0] rf_rd_data2,
  input  logic                  rf_wr_ack,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WAIT_ACK,
    S_RD,
    S_RD_CAP,
    S_RESP
  } state_e;

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0] rd_addr1_q, rd_addr1_d;
  logic [ADDR_WIDTH-1:0] rd_addr2_q, rd_addr2_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_a_q, rsp_a_d;
  logic [DATA_WIDTH-1:0] rsp_b_q, rsp_b_d;
  logic                  rsp_err_q, rsp_err_d;
`ifdef WRITE_VERIFY_EN
  logic                  vfy_q, vfy_d;
`endif

  // Next-state and registered-output decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_en_d     = wr_en_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_addr1_d  = rd_addr1_q;
    rd_addr2_d  = rd_addr2_q;
    rsp_valid_d = rsp_valid_q;
    rsp_a_d     = rsp_a_q;
    rsp_b_d     = rsp_b_q;
    rsp_err_d   = rsp_err_q;
`ifdef WRITE_VERIFY_EN
    vfy_d       = vfy_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_write) begin
            state_d   = S_WR;
            wr_en_d   = 1'b1;
            wr_addr_d = cmd_addr_a;
            wr_data_d = cmd_wdata;
          end else begin
            state_d    = S_RD;
            rd_addr1_d = cmd_addr_a;
            rd_addr2_d = cmd_addr_b;
`ifdef WRITE_VERIFY_EN
            vfy_d      = 1'b0;
`endif
          end
        end
      end
      S_WR: begin
        wr_en_d = 1'b0;
        cnt_d   = '0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (rf_wr_ack) begin
`ifdef WRITE_VERIFY_EN
          state_d    = S_RD;
          rd_addr1_d = wr_addr_q;
          vfy_d      = 1'b1;
`else
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_a_d     = '0;
          rsp_b_d     = '0;
          rsp_err_d   = 1'b0;
`endif
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_a_d     = '0;
          rsp_b_d     = '0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RD: begin
        state_d = S_RD_CAP;
      end
      S_RD_CAP: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_a_d     = rf_rd_data1;
        rsp_b_d     = rf_rd_data2;
        rsp_err_d   = 1'b0;
`ifdef WRITE_VERIFY_EN
        if (vfy_q) begin
          rsp_b_d   = '0;
          rsp_err_d = (rf_rd_data1 != wr_data_q);
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_addr1_q  <= '0;
      rd_addr2_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_a_q     <= '0;
      rsp_b_q     <= '0;
      rsp_err_q   <= 1'b0;
`ifdef WRITE_VERIFY_EN
      vfy_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_addr1_q  <= rd_addr1_d;
      rd_addr2_q  <= rd_addr2_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_a_q     <= rsp_a_d;
      rsp_b_q     <= rsp_b_d;
      rsp_err_q   <= rsp_err_d;
`ifdef WRITE_VERIFY_EN
      vfy_q       <= vfy_d;
`endif
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = !cmd_ready;
  assign rf_wr_en    = wr_en_q;
  assign rf_wr_addr  = wr_addr_q;
  assign rf_wr_data  = wr_data_q;
  assign rf_rd_addr1 = rd_addr1_q;
  assign rf_rd_addr2 = rd_addr2_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data_a  = rsp_a_q;
  assign rsp_data_b  = rsp_b_q;
  assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb_regfile_access_ctrl: directed vectors against a behavioural register file.
// Expected values follow WRITE_VERIFY_EN when it is defined.
module tb_regfile_access_ctrl;

`ifdef WRITE_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif
  localparam int XL = VFY ? 2 : 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [4:0]  cmd_addr_a = '0;
  logic [4:0]  cmd_addr_b = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data_a;
  logic [31:0] rsp_data_b;
  logic        rsp_err;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic [4:0]  rf_rd_addr1;
  logic [4:0]  rf_rd_addr2;
  logic [31:0] rf_rd_data1 = '0;
  logic [31:0] rf_rd_data2 = '0;
  logic        rf_wr_ack = 1'b0;
  logic        busy;

  regfile_access_ctrl #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5),
    .ACK_TIMEOUT(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr_a (cmd_addr_a),
    .cmd_addr_b (cmd_addr_b),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data_a (rsp_data_a),
    .rsp_data_b (rsp_data_b),
    .rsp_err    (rsp_err),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .rf_rd_addr1(rf_rd_addr1),
    .rf_rd_addr2(rf_rd_addr2),
    .rf_rd_data1(rf_rd_data1),
    .rf_rd_data2(rf_rd_data2),
    .rf_wr_ack  (rf_wr_ack),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Register file model: ack ack_dly edges after it samples rf_wr_en
  logic [31:0] mem [32];
  bit          loaded = 1'b0;
  int          age = 100;
  int          ack_dly = 1;
  bit          corrupt = 1'b0;
  bit          stray_ack = 1'b0;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'(i);
      loaded <= 1'b1;
    end else if (rf_wr_en) begin
      mem[rf_wr_addr] <= corrupt ? (rf_wr_data ^ 32'h1) : rf_wr_data;
    end
    if (rf_wr_en) age <= 1;
    else if (age < 100) age <= age + 1;
    rf_wr_ack <= stray_ack ||
      (ack_dly != 0 && (rf_wr_en ? 1 : age + 1) == ack_dly);
    rf_rd_data1 <= mem[rf_rd_addr1];
    rf_rd_data2 <= mem[rf_rd_addr2];
  end

  // Write-strobe monitor
  int          wr_total = 0;
  logic [4:0]  wr_addr_seen = '0;
  logic [31:0] wr_data_seen = '0;
  always @(negedge clk) begin
    if (rf_wr_en) begin
      wr_total     <= wr_total + 1;
      wr_addr_seen <= rf_wr_addr;
      wr_data_seen <= rf_wr_data;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [31:0] wd;
    int          dly;
    bit          cor;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        eerr;
    int          elat;
  } vec_t;

  vec_t vt[10];

  // Issue one command and return the edge count to rsp_valid (0 = none)
  task automatic issue(input vec_t v, output int lat);
    @(negedge clk);
    ack_dly    = v.dly;
    corrupt    = v.cor;
    cmd_valid  = 1'b1;
    cmd_write  = v.wr;
    cmd_addr_a = v.a;
    cmd_addr_b = v.b;
    cmd_wdata  = v.wd;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        lat = n + 1;
        break;
      end
    end
  endtask

  task automatic consume(input string nm);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk({nm, " valid drop"}, 32'(rsp_valid), 32'h0);
    chk({nm, " ready back"}, 32'(cmd_ready), 32'h1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int   lat;
    int   w0;
    bit   stray_seen;
    logic [31:0] ha, hb;
    logic        he;
    string nm;

    vt[0] = '{1'b1, 5'd5, 5'd0, 32'hDEADBEEF, 1, 1'b0,
              VFY ? 32'hDEADBEEF : 32'h0, 32'h0, 1'b0, 3 + XL};
    vt[1] = '{1'b0, 5'd5, 5'd9, 32'h0, 1, 1'b0,
              32'hDEADBEEF, 32'h00000009, 1'b0, 3};
    vt[2] = '{1'b1, 5'd31, 5'd0, 32'hA5A5A5A5, 0, 1'b0,
              32'h0, 32'h0, 1'b1, 6};
    vt[3] = '{1'b0, 5'd31, 5'd0, 32'h0, 1, 1'b0,
              32'hA5A5A5A5, 32'h0, 1'b0, 3};
    vt[4] = '{1'b1, 5'd3, 5'd0, 32'hCAFEF00D, 4, 1'b0,
              VFY ? 32'hCAFEF00D : 32'h0, 32'h0, 1'b0, 6 + XL};
    vt[5] = '{1'b1, 5'd4, 5'd0, 32'h11112222, 5, 1'b0,
              32'h0, 32'h0, 1'b1, 6};
    vt[6] = '{1'b1, 5'd7, 5'd0, 32'h12345678, 1, 1'b1,
              VFY ? 32'h12345679 : 32'h0, 32'h0, VFY, 3 + XL};
    vt[7] = '{1'b0, 5'd7, 5'd4, 32'h0, 1, 1'b0,
              32'h12345679, 32'h11112222, 1'b0, 3};
    vt[8] = '{1'b1, 5'd0, 5'd0, 32'hFFFFFFFF, 2, 1'b0,
              VFY ? 32'hFFFFFFFF : 32'h0, 32'h0, 1'b0, 4 + XL};
    vt[9] = '{1'b0, 5'd0, 5'd3, 32'h0, 1, 1'b0,
              32'hFFFFFFFF, 32'hCAFEF00D, 1'b0, 3};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst cmd_ready", 32'(cmd_ready), 32'h1);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst rf_wr_en", 32'(rf_wr_en), 32'h0);
    chk("rst rsp_data_a", rsp_data_a, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-WR drops the command
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_write  = 1'b1;
    cmd_addr_a = 5'd5;
    cmd_wdata  = 32'h0BAD0BAD;
    ack_dly    = 1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    chk("midwr wr_en", 32'(rf_wr_en), 32'h1);
    chk("midwr busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst wr_en", 32'(rf_wr_en), 32'h0);
    chk("midrst cmd_ready", 32'(cmd_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    stray_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 if (rsp_valid || busy) stray_seen = 1'b1;
    end
    chk("midrst no rsp", 32'(stray_seen), 32'h0);

    // Table-driven command vectors
    for (int i = 0; i < 10; i++) begin
      w0 = wr_total;
      issue(vt[i], lat);
      nm = $sformatf("v%0d", i);
      chk({nm, " lat"}, 32'(lat), 32'(vt[i].elat));
      chk({nm, " data_a"}, rsp_data_a, vt[i].ea);
      chk({nm, " data_b"}, rsp_data_b, vt[i].eb);
      chk({nm, " err"}, 32'(rsp_err), 32'(vt[i].eerr));
      chk({nm, " busy"}, 32'(busy), 32'h1);
      if (vt[i].wr) begin
        chk({nm, " wr pulses"}, 32'(wr_total - w0), 32'h1);
        chk({nm, " wr addr"}, 32'(wr_addr_seen), 32'(vt[i].a));
        chk({nm, " wr data"}, wr_data_seen, vt[i].wd);
      end else begin
        chk({nm, " rd addr1"}, 32'(rf_rd_addr1), 32'(vt[i].a));
        chk({nm, " rd addr2"}, 32'(rf_rd_addr2), 32'(vt[i].b));
      end
      consume(nm);
    end

    // Backpressure on a read response with a stray ack
    issue(vt[1], lat);
    chk("bp lat", 32'(lat), 32'h3);
    ha = rsp_data_a;
    hb = rsp_data_b;
    he = rsp_err;
    chk("bp data_a", ha, 32'hDEADBEEF);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      stray_ack = (c == 1);
      chk($sformatf("bp%0d valid", c), 32'(rsp_valid), 32'h1);
      chk($sformatf("bp%0d a", c), rsp_data_a, ha);
      chk($sformatf("bp%0d b", c), rsp_data_b, hb);
      chk($sformatf("bp%0d err", c), 32'(rsp_err), 32'(he));
      chk($sformatf("bp%0d cmd_ready", c), 32'(cmd_ready), 32'h0);
    end
    stray_ack = 1'b0;
    consume("bp");

    // Stray ack while idle never creates a response
    @(negedge clk);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    stray_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 if (rsp_valid || !cmd_ready) stray_seen = 1'b1;
    end
    chk("idle stray ack", 32'(stray_seen), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
